// File: rtl/tdc_trace_capture.sv
// rtl/tdc_trace_capture.sv - TDC tap encoder, decimator and one-shot trace buffer with stream readout
module tdc_trace_capture #(
    parameter int TAPS    = 64,
    parameter int DEPTH   = 1024,
    parameter int DECIM_W = 8,
    localparam int CODE_W = $clog2(TAPS + 1),
    localparam int SAMP_W = CODE_W + DECIM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TAPS-1:0]     taps_in,
    input  logic                esp_trigger,
    input  logic                arm,
    input  logic                pol_alt,
    input  logic [DECIM_W-1:0]  decim,
    output logic                busy,
    output logic                armed,
    output logic                done,
    output logic [SAMP_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 phase_q, phase_d;
    logic [TAPS-1:0]      s1_q, s1_d;
    logic [CODE_W-1:0]    s2_q, s2_d;
    logic                 trig_q, trig_d;
    logic [DECIM_W-1:0]   dec_l_q, dec_l_d;
    logic [DECIM_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [SAMP_W-1:0]    acc_q, acc_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_last_q, rd_last_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 armed_q, armed_d;
    logic [SAMP_W-1:0]    rd_data_q;

    logic                 trig_rise;
    logic [SAMP_W-1:0]    sum;
    logic                 wr_en;
    logic [PTR_W-1:0]     rd_addr;

    logic [SAMP_W-1:0]    trace_mem [DEPTH];

    // Encode pipe: polarity-corrected snapshot, then bubble-tolerant ones count.
    always_comb begin
        phase_d = ~phase_q;
        s1_d    = taps_in ^ {TAPS{pol_alt & phase_q}};
        trig_d  = esp_trigger;
        s2_d    = '0;
        for (int i = 0; i < TAPS; i++) begin
            s2_d = s2_d + CODE_W'(s1_q[i]);
        end
    end

    assign trig_rise = esp_trigger & ~trig_q;

    // Next-state logic: arm/trigger sequencing, decimating capture and stream readout.
    always_comb begin
        state_d    = state_q;
        dec_l_d    = dec_l_q;
        dec_cnt_d  = dec_cnt_q;
        acc_d      = acc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        rd_addr    = rd_ptr_q;
        sum        = acc_q + SAMP_W'(s2_q);
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
            end
            ARMED: begin
                if (trig_rise) begin
                    state_d   = CAPTURE;
                    dec_l_d   = decim;
                    dec_cnt_d = '0;
                    acc_d     = '0;
                    wr_ptr_d  = '0;
                end
            end
            CAPTURE: begin
                if (dec_cnt_q == dec_l_q) begin
                    wr_en     = 1'b1;
                    acc_d     = '0;
                    dec_cnt_d = '0;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d  = READOUT;
                        rd_ptr_d = '0;
                    end
                end else begin
                    acc_d     = sum;
                    dec_cnt_d = dec_cnt_q + 1'b1;
                end
            end
            READOUT: begin
                // Stalled cycles re-read the same address, so rd_data stays put.
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_ptr_q == LAST_PTR);
                end else if (rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        rd_addr   = rd_ptr_q + 1'b1;
                        rd_last_d = ((rd_ptr_q + 1'b1) == LAST_PTR);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        armed_d = (state_d == ARMED);
    end

    // Control, pipeline and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            trig_q     <= 1'b0;
            dec_l_q    <= '0;
            dec_cnt_q  <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            trig_q     <= trig_d;
            dec_l_q    <= dec_l_d;
            dec_cnt_q  <= dec_cnt_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
        end
    end

    // Trace buffer write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) trace_mem[wr_ptr_q] <= sum;
    end

    // Synchronous read port feeding the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (state_q == READOUT) begin
            rd_data_q <= trace_mem[rd_addr];
        end
    end

    assign busy     = busy_q;
    assign armed    = armed_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;

endmodule
